ah_snoop_requester: RTL and testbench



---
 rtl/ah_snoop_pkg.sv | 15 +
 rtl/ah_down_counter.sv | 36 +++
 rtl/ah_snoop_requester.sv | 151 +++++++++++++++
 tb/tb_ah_snoop_requester.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ah_snoop_pkg.sv
// Shared types and constants for the snoop requester and snoopable FIFO.
package ah_snoop_pkg;

    localparam int unsigned RETRY_W        = 4;
    localparam int unsigned DEF_DATA_WIDTH = 40;

    typedef enum logic [2:0] {
        StIdle,
        StSnoop,
        StWait,
        StBackoff,
        StOut
    } state_e;

endpackage

// File: rtl/ah_down_counter.sv
// Loadable down counter that saturates at zero and flags when it is zero.
module ah_down_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load has priority over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ah_snoop_requester.sv
// Snoop initiator: snoops each request word against the FIFO, backs off and
// retries while it still matches, then forwards it tagged hit/miss.
module ah_snoop_requester
    import ah_snoop_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned SMATCH_LAT  = 1,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned BACKOFF_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [DATA_WIDTH-1:0] sdata,
    output logic                  svalid,
    input  logic                  smatch,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rhit,
    output logic [RETRY_W-1:0]    rretry
);

    localparam int unsigned LatW = 3;
    localparam int unsigned BoW  = 8;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] req_q, req_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic                  hit_q, hit_d;

    logic                  wready_q, svalid_q, rvalid_q, rhit_q;
    logic [DATA_WIDTH-1:0] sdata_q, rdata_q;
    logic [RETRY_W-1:0]    rretry_q;

    logic lat_load, lat_dec, lat_zero;
    logic bo_load, bo_dec, bo_zero;

    ah_down_counter #(.Width(LatW)) u_lat_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (lat_load),
        .load_val_i (LatW'(SMATCH_LAT - 1)),
        .dec_i      (lat_dec),
        .zero_o     (lat_zero)
    );

    ah_down_counter #(.Width(BoW)) u_bo_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (bo_load),
        .load_val_i (BoW'(BACKOFF_CYC - 1)),
        .dec_i      (bo_dec),
        .zero_o     (bo_zero)
    );

    // Next-state and datapath; smatch is only looked at in the sample cycle.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        retry_d  = retry_q;
        hit_d    = hit_q;
        lat_load = 1'b0;
        lat_dec  = 1'b0;
        bo_load  = 1'b0;
        bo_dec   = 1'b0;
        case (state_q)
            StIdle: begin
                if (wvalid) begin
                    req_d   = wdata;
                    retry_d = '0;
                    hit_d   = 1'b0;
                    state_d = StSnoop;
                end
            end
            StSnoop: begin
                lat_load = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if (!lat_zero) begin
                    lat_dec = 1'b1;
                end else if (!smatch) begin
                    hit_d   = 1'b0;
                    state_d = StOut;
                end else if (retry_q != RETRY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    bo_load = 1'b1;
                    state_d = StBackoff;
                end else begin
                    hit_d   = 1'b1;
                    state_d = StOut;
                end
            end
            StBackoff: begin
                if (bo_zero) begin
                    state_d = StSnoop;
                end else begin
                    bo_dec = 1'b1;
                end
            end
            StOut: begin
                if (rready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, request holding and registered outputs; outputs follow the next state
    // so they are valid in the same cycle the state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            req_q    <= '0;
            retry_q  <= '0;
            hit_q    <= 1'b0;
            wready_q <= 1'b1;
            svalid_q <= 1'b0;
            sdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rhit_q   <= 1'b0;
            rretry_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            retry_q  <= retry_d;
            hit_q    <= hit_d;
            wready_q <= (state_d == StIdle);
            svalid_q <= (state_d == StSnoop);
            sdata_q  <= (state_d == StSnoop) ? req_d : '0;
            rvalid_q <= (state_d == StOut);
            rdata_q  <= (state_d == StOut) ? req_d : '0;
            rhit_q   <= (state_d == StOut) ? hit_d : 1'b0;
            rretry_q <= (state_d == StOut) ? retry_d : '0;
        end
    end

    assign wready = wready_q;
    assign svalid = svalid_q;
    assign sdata  = sdata_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rhit   = rhit_q;
    assign rretry = rretry_q;

endmodule

// File: tb/tb_ah_snoop_requester.sv
// Bench for ah_snoop_requester: table of requests with a scoreboard, plus
// sequences for backpressure, asynchronous reset and smatch latency.
module tb_ah_snoop_requester;

    localparam int DW = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] sdata;
    logic          svalid;
    logic          smatch;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          rhit;
    logic [3:0]    rretry;

    logic          sw_wvalid;
    logic [DW-1:0] sw_wdata;
    logic          sw_smatch [4];
    logic          sw_wready [4];
    logic [DW-1:0] sw_sdata  [4];
    logic          sw_svalid [4];
    logic [DW-1:0] sw_rdata  [4];
    logic          sw_rvalid [4];
    logic          sw_rhit   [4];
    logic [3:0]    sw_rretry [4];
    logic          sw_rready;

    always #5 clk = ~clk;

    ah_snoop_requester #(
        .DATA_WIDTH  (DW),
        .SMATCH_LAT  (1),
        .MAX_RETRY   (3),
        .BACKOFF_CYC (4)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wready (wready),
        .sdata  (sdata),
        .svalid (svalid),
        .smatch (smatch),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rready (rready),
        .rhit   (rhit),
        .rretry (rretry)
    );

    // One instance per smatch latency; MAX_RETRY=0 so a hit shows directly on rhit.
    for (genvar g = 0; g < 4; g++) begin : g_sw
        ah_snoop_requester #(
            .DATA_WIDTH  (DW),
            .SMATCH_LAT  (g + 1),
            .MAX_RETRY   (0),
            .BACKOFF_CYC (4)
        ) u_sw (
            .clk    (clk),
            .rst    (rst),
            .wdata  (sw_wdata),
            .wvalid (sw_wvalid),
            .wready (sw_wready[g]),
            .sdata  (sw_sdata[g]),
            .svalid (sw_svalid[g]),
            .smatch (sw_smatch[g]),
            .rdata  (sw_rdata[g]),
            .rvalid (sw_rvalid[g]),
            .rready (sw_rready),
            .rhit   (sw_rhit[g]),
            .rretry (sw_rretry[g])
        );
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    pat;   // bit k = smatch answer for the k-th snoop
        logic          hit;
        logic [3:0]    retry;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          hit;
        logic [3:0]    retry;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       next_exp;
    vec_t       vecs[7];
    logic [3:0] cur_pat;

    int cyc, n_chk, n_pass;
    int acc_n, done_n, acc_cyc, rv_rise, sv_n, sv_tot, rv_tot, snoop_k;
    int wr_err, zero_err, stab_err;
    int sv_cyc[16];
    bit busy, rv_prev, rr_prev, rh_prev;
    logic [DW-1:0] rd_prev;
    logic [3:0]    rt_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Mid-cycle observer: scoreboard, snoop responder and protocol rule tracking.
    task automatic mon();
        exp_t          e;
        logic [DW-1:0] exp_sd;
        if (rst) begin
            sb_q.delete();
            busy    = 0;
            rv_prev = 0;
            rr_prev = 0;
            return;
        end
        if (busy && wready) wr_err++;
        if (!svalid && sdata != '0) zero_err++;
        if (!rvalid && (rdata != '0 || rhit || rretry != 4'd0)) zero_err++;
        if (rv_prev && !rr_prev &&
            (!rvalid || rdata != rd_prev || rhit != rh_prev || rretry != rt_prev)) stab_err++;
        if (svalid) begin
            sv_tot++;
            if (sv_n < 16) sv_cyc[sv_n[3:0]] = cyc;
            sv_n++;
            exp_sd = (sb_q.size() > 0) ? sb_q[0].data : '0;
            check("sdata", 64'(sdata), 64'(exp_sd));
            smatch = (snoop_k < 4) ? cur_pat[snoop_k[1:0]] : 1'b0;
            snoop_k++;
        end
        if (rvalid) begin
            rv_tot++;
            if (!rv_prev) rv_rise = cyc;
        end
        if (rvalid && rready) begin
            if (sb_q.size() == 0) begin
                check("rvalid_unexpected", 64'(rvalid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("rdata", 64'(rdata), 64'(e.data));
                check("rhit", 64'(rhit), 64'(e.hit));
                check("rretry", 64'(rretry), 64'(e.retry));
            end
            busy = 0;
            done_n++;
        end
        if (wvalid && wready) begin
            sb_q.push_back(next_exp);
            busy    = 1;
            acc_n++;
            acc_cyc = cyc;
            sv_n    = 0;
            snoop_k = 0;
        end
        rv_prev = rvalid;
        rr_prev = rready;
        rd_prev = rdata;
        rh_prev = rhit;
        rt_prev = rretry;
    endtask

    // Advance one cycle; returns just after the rising edge of the new cycle.
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_req(input vec_t v);
        int a0, d0, n;
        next_exp.data  = v.data;
        next_exp.hit   = v.hit;
        next_exp.retry = v.retry;
        cur_pat        = v.pat;
        a0     = acc_n;
        d0     = done_n;
        wvalid = 1'b1;
        wdata  = v.data;
        n      = 0;
        while (done_n == d0 && n < 200) begin
            tick();
            if (acc_n != a0) wvalid = 1'b0;
            n++;
        end
        wvalid = 1'b0;
        check("req_done", 64'(done_n - d0), 64'(1));
        if (done_n != d0) begin
            for (int k = 0; k <= int'(v.retry); k++)
                check("svalid_cycle", 64'(sv_cyc[k[3:0]]), 64'(acc_cyc + 1 + 6 * k));
            check("svalid_count", 64'(sv_n), 64'(int'(v.retry) + 1));
            check("rvalid_latency", 64'(rv_rise), 64'(acc_cyc + 3 + 6 * int'(v.retry)));
        end
        check("wready_busy", 64'(wr_err), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a0, d0, n, t0, s0, r0;
        wvalid = 0; wdata = '0; smatch = 0; rready = 1'b1;
        sw_wvalid = 0; sw_wdata = '0; sw_rready = 1'b1;
        for (int i = 0; i < 4; i++) sw_smatch[i] = 1'b0;
        cur_pat = '0;
        cyc = 0; n_chk = 0; n_pass = 0;
        acc_n = 0; done_n = 0; acc_cyc = 0; rv_rise = 0; sv_n = 0; sv_tot = 0; rv_tot = 0;
        snoop_k = 0; wr_err = 0; zero_err = 0; stab_err = 0;
        busy = 0; rv_prev = 0; rr_prev = 0; rh_prev = 0; rd_prev = '0; rt_prev = '0;
        for (int i = 0; i < 16; i++) sv_cyc[i] = 0;

        vecs[0] = '{data: 40'hA5A5_0000_01, pat: 4'b0000, hit: 1'b0, retry: 4'd0};
        vecs[1] = '{data: 40'h12_3456_789A, pat: 4'b0001, hit: 1'b0, retry: 4'd1};
        vecs[2] = '{data: 40'hFF_FFFF_FFFF, pat: 4'b0011, hit: 1'b0, retry: 4'd2};
        vecs[3] = '{data: 40'h00_0000_0000, pat: 4'b0111, hit: 1'b0, retry: 4'd3};
        vecs[4] = '{data: 40'h80_0000_0001, pat: 4'b1111, hit: 1'b1, retry: 4'd3};
        vecs[5] = '{data: 40'h5A_5A5A_5A5A, pat: 4'b1011, hit: 1'b0, retry: 4'd2};
        vecs[6] = '{data: 40'hC3_C3C3_C3C3, pat: 4'b1110, hit: 1'b0, retry: 4'd0};

        // Reset values, while in reset and just after release.
        repeat (3) tick();
        check("rst_wready", 64'(wready), 64'(1));
        check("rst_svalid", 64'(svalid), 64'(0));
        check("rst_sdata", 64'(sdata), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_rhit", 64'(rhit), 64'(0));
        check("rst_rretry", 64'(rretry), 64'(0));
        rst = 1'b0;
        tick();
        check("idle_after_rst", 64'({wready, svalid, rvalid}), 64'(3'b100));

        for (int i = 0; i < 7; i++) do_req(vecs[i]);

        // Backpressure: output held stable, no new request taken.
        next_exp = '{data: 40'h0F_0FF0_F033, hit: 1'b0, retry: 4'd0};
        cur_pat  = 4'b0000;
        rready   = 1'b0;
        a0 = acc_n;
        wvalid = 1'b1;
        wdata  = 40'h0F_0FF0_F033;
        n = 0;
        while (!rvalid && n < 50) begin
            tick();
            if (acc_n != a0) wvalid = 1'b0;
            n++;
        end
        check("bp_rvalid_seen", 64'(rvalid), 64'(1));
        wvalid = 1'b1;
        wdata  = 40'hDE_ADBE_EF00;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold", 64'({rvalid, rhit, rretry, rdata}),
                  64'({1'b1, 1'b0, 4'd0, 40'h0F_0FF0_F033}));
            check("bp_wready", 64'(wready), 64'(0));
        end
        wvalid = 1'b0;
        rready = 1'b1;
        d0 = done_n;
        tick();
        check("bp_done", 64'(done_n - d0), 64'(1));
        check("bp_idle", 64'({wready, rvalid}), 64'(2'b10));

        // Asynchronous reset in the middle of backoff.
        next_exp = '{data: 40'h77_7788_8899, hit: 1'b1, retry: 4'd3};
        cur_pat  = 4'b1111;
        a0 = acc_n;
        wvalid = 1'b1;
        wdata  = 40'h77_7788_8899;
        n = 0;
        while (acc_n == a0 && n < 20) begin
            tick();
            n++;
        end
        wvalid = 1'b0;
        while (cyc < acc_cyc + 4 && n < 40) begin
            tick();
            n++;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_ctrl", 64'({wready, svalid, rvalid, rhit, rretry}), 64'(8'b1000_0000));
        check("arst_sdata", 64'(sdata), 64'(0));
        check("arst_rdata", 64'(rdata), 64'(0));
        repeat (2) tick();
        rst = 1'b0;
        s0 = sv_tot;
        r0 = rv_tot;
        repeat (30) tick();
        check("post_rst_svalid", 64'(sv_tot - s0), 64'(0));
        check("post_rst_rvalid", 64'(rv_tot - r0), 64'(0));
        check("post_rst_wready", 64'(wready), 64'(1));
        do_req(vecs[1]);

        // smatch latency sweep: pulse only in the sample cycle, or one early/late.
        sw_wdata = 40'h13_579B_DF02;
        for (int off = -1; off <= 1; off++) begin
            tick();
            sw_wvalid = 1'b1;
            t0 = cyc;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (c == 0) sw_wvalid = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    sw_smatch[i] = (cyc == t0 + 2 + i + off);
                    if (cyc == t0 + 1)
                        check("sw_svalid", 64'({sw_svalid[i], sw_sdata[i]}),
                              64'({1'b1, sw_wdata}));
                    if (cyc == t0 + 3 + i)
                        check("sw_out", 64'({sw_rvalid[i], sw_rhit[i], sw_rretry[i], sw_rdata[i]}),
                              64'({1'b1, (off == 0), 4'd0, sw_wdata}));
                end
            end
            for (int i = 0; i < 4; i++) sw_smatch[i] = 1'b0;
            check("sw_idle", 64'({sw_wready[0], sw_wready[1], sw_wready[2], sw_wready[3]}),
                  64'(4'hF));
        end

        check("zero_when_invalid", 64'(zero_err), 64'(0));
        check("rvalid_stable", 64'(stab_err), 64'(0));
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
